sr_button_conditioner: RTL and testbench
========================================

Name: sr_button_conditioner

Overview:
- Upstream front end for the SR-on-D flip-flop stage.
- Takes two raw asynchronous push-button inputs (set, reset), synchronises and debounces each one, and converts each debounced press into a single-cycle command pulse on s / r.
- Guarantees s and r are never asserted together; a simultaneous press is flagged on conflict and both commands are dropped.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive cycles a synchronised input must differ from its debounced level before that level flips. Legal range ≥ 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): debounce counter width. Derived; never overridden.

Ports:
- clk        input   1  single system clock, all flops on posedge
- rst        input   1  synchronous, active-high reset
- btn_set    input   1  raw asynchronous set button, active-high
- btn_reset  input   1  raw asynchronous reset button, active-high
- s          output  1  one-cycle set command to the SR stage, registered
- r          output  1  one-cycle reset command to the SR stage, registered
- conflict   output  1  one-cycle flag: both presses qualified on the same edge, registered
- set_level  output  1  debounced level of btn_set
- rst_level  output  1  debounced level of btn_reset

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. While rst=1 at a posedge, every flop clears to 0: sync stages, counters, debounced levels, edge-history flops, s, r, conflict, set_level and rst_level.
- Per channel (identical for set and reset):
  - Two-flop synchroniser: sync1 <= btn; sync2 <= sync1.
  - Debounce counter cnt. If sync2 == level, cnt <= 0. Otherwise, if cnt == DEBOUNCE_CYCLES-1, then level <= sync2 and cnt <= 0. Otherwise cnt <= cnt+1.
  - Qualified press: level is 1 while level_d (level delayed one cycle) is 0. Release edges (1->0) are debounced the same way but never generate a command.
- Output stage, registered, evaluated every posedge:
  - Only the set press qualified: s <= 1, r <= 0, conflict <= 0.
  - Only the reset press qualified: r <= 1, s <= 0, conflict <= 0.
  - Both qualified on the same edge: s <= 0, r <= 0, conflict <= 1.
  - Neither qualified: all three <= 0.
- Latency, with N = DEBOUNCE_CYCLES and btn first sampled high at edge 0 and held:
  - sync2 = 1 after edge 1.
  - cnt = N-1 after edge N.
  - level = 1 after edge N+1.
  - s = 1 after edge N+2 and back to 0 after edge N+3 (exactly one cycle).
- Glitch rejection: if sync2 returns to level before cnt reaches N-1, cnt clears and no pulse is produced. A bounce restarts the count from 0.
- Held button: produces exactly one pulse per press, regardless of hold length.
- Reset mid-count: the count is discarded. If the button is still held when rst deasserts, the level is 0 again, so counting restarts and one pulse is produced N+3 edges after the first non-reset edge.
- Pulses from the two channels in different cycles are independent. Back-to-back qualified presses on one channel cannot occur, because a release must debounce first.
- Invariant: s & r == 0 in every cycle. conflict is high only when s and r are both 0.

Decomposition:
- Shared package sr_pkg: CNT_W derivation helper and the DEBOUNCE_CYCLES default constant (reused by the SR stage testbench).
- One natural sub-module, debounce_channel: synchroniser, counter and level register; outputs level and a rising-edge press pulse. Instantiated twice.
- The top level holds only the output arbitration registers.

Test Plan:
- Reset: DEBOUNCE_CYCLES=4, rst=1 for 3 edges with both buttons high -> s, r, conflict, set_level and rst_level all 0 throughout reset.
- Clean set press: btn_set high from edge 0, held 20 cycles -> set_level=1 after edge 5; s=1 only between edges 6 and 7; r=0 and conflict=0 throughout.
- Bounce rejection: btn_set toggles high 2 cycles / low 1 cycle, repeated 5 times, then low -> s never asserts, set_level stays 0. Then a 6-cycle high pulse -> exactly one s pulse.
- Simultaneous press: btn_set and btn_reset rise at the same edge 0 -> conflict=1 between edges 6 and 7; s=0 and r=0 for the whole run.
- Staggered presses: btn_reset rises 1 cycle after btn_set -> s pulse between edges 6 and 7, r pulse between edges 7 and 8, never overlapping.
- Reset mid-operation: btn_reset held; rst pulsed at edge 3 (mid-count) -> no r pulse from the aborted count; one r pulse 7 edges after rst deasserts; a release then re-press gives a second pulse.

Source files
------------

// File: rtl/sr_pkg.sv
// Shared constants for the SR button front end and the SR stage that consumes it.
package sr_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 16;

    // Width needed to hold a count of 0..cycles.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/sr_button_conditioner_if.sv
// Button inputs and conditioned command outputs of the SR front end.
interface sr_button_conditioner_if;

    logic btn_set;
    logic btn_reset;
    logic s;
    logic r;
    logic conflict;
    logic set_level;
    logic rst_level;

    modport master (
        output btn_set,
        output btn_reset,
        input  s,
        input  r,
        input  conflict,
        input  set_level,
        input  rst_level
    );

    modport slave (
        input  btn_set,
        input  btn_reset,
        output s,
        output r,
        output conflict,
        output set_level,
        output rst_level
    );

endinterface

// File: rtl/sr_button_conditioner_debounce_channel.sv
// One button channel: two-flop synchroniser, debounce counter, debounced level
// and a one-cycle rising-edge press indication.
module debounce_channel
    import sr_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int               CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             level_dly_q, level_dly_d;

    always_comb begin
        sync1_d     = btn;
        sync2_d     = sync1_q;
        level_dly_d = level_q;
        level_d     = level_q;
        cnt_d       = cnt_q;
        // Any sample agreeing with the current level restarts the qualification window.
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
        end
    end

    assign level = level_q;
    assign press = level_q & ~level_dly_q;

endmodule

// File: rtl/sr_button_conditioner.sv
// Button conditioner top: two debounced channels feeding registered s/r/conflict
// arbitration so that s and r are never high together.
module sr_button_conditioner
    import sr_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input logic                     clk,
    input logic                     rst,
    sr_button_conditioner_if.slave  bus
);

    logic set_level_w, set_press_w;
    logic rst_level_w, rst_press_w;

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_ch (
        .clk   (clk),
        .rst   (rst),
        .btn   (bus.btn_set),
        .level (set_level_w),
        .press (set_press_w)
    );

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rst_ch (
        .clk   (clk),
        .rst   (rst),
        .btn   (bus.btn_reset),
        .level (rst_level_w),
        .press (rst_press_w)
    );

    logic s_q, s_d;
    logic r_q, r_d;
    logic conflict_q, conflict_d;

    // Simultaneous presses are ambiguous, so both commands are dropped and flagged.
    always_comb begin
        s_d        = set_press_w & ~rst_press_w;
        r_d        = rst_press_w & ~set_press_w;
        conflict_d = set_press_w &  rst_press_w;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            s_q        <= s_d;
            r_q        <= r_d;
            conflict_q <= conflict_d;
        end
    end

    assign bus.s         = s_q;
    assign bus.r         = r_q;
    assign bus.conflict  = conflict_q;
    assign bus.set_level = set_level_w;
    assign bus.rst_level = rst_level_w;

endmodule

// File: tb/tb_sr_button_conditioner.sv
// Directed bench for sr_button_conditioner with DEBOUNCE_CYCLES = 4.
module tb_sr_button_conditioner;

    localparam int N = 4;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    sr_button_conditioner_if bus ();

    sr_button_conditioner #(.DEBOUNCE_CYCLES(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector order: {s, r, conflict, set_level, rst_level}
    function automatic logic [4:0] obs();
        return {bus.s, bus.r, bus.conflict, bus.set_level, bus.rst_level};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.btn_set   = 1'b0;
        bus.btn_reset = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        logic [4:0] got;
        bus.btn_set   = 1'b1;
        bus.btn_reset = 1'b1;
        rst = 1'b1;
        for (int e = 0; e < 3; e++) begin
            step();
            got = obs();
            n_cmp++;
            if (got !== 5'b00000) begin
                n_bad++;
                $display("FAIL reset e=%0d got=%b expected=%b", e, got, 5'b00000);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_clean_set();
        logic [4:0] got, exp;
        do_reset();
        bus.btn_set = 1'b1;
        for (int e = 0; e < 20; e++) begin
            step();
            got = obs();
            exp = {(e == 6), 1'b0, 1'b0, (e >= 5), 1'b0};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL clean_set e=%0d got=%b expected=%b", e, got, exp);
            end
        end
    endtask

    task automatic test_bounce();
        logic [4:0] got, exp;
        int pulses;
        do_reset();
        for (int i = 0; i < 23; i++) begin
            bus.btn_set = (i < 15) && ((i % 3) != 2);
            step();
            got = obs();
            n_cmp++;
            if (got !== 5'b00000) begin
                n_bad++;
                $display("FAIL bounce i=%0d got=%b expected=%b", i, got, 5'b00000);
            end
        end
        pulses = 0;
        for (int e = 0; e < 20; e++) begin
            bus.btn_set = (e < 6);
            step();
            got = obs();
            pulses += int'(got[4]);
            exp = {(e == 6), 1'b0, 1'b0, (e >= 5) && (e < 11), 1'b0};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL bounce_pulse e=%0d got=%b expected=%b", e, got, exp);
            end
        end
        n_cmp++;
        if (pulses !== 1) begin
            n_bad++;
            $display("FAIL bounce_pulse_count got=%0d expected=1", pulses);
        end
        bus.btn_set = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [4:0] got, exp;
        do_reset();
        bus.btn_set   = 1'b1;
        bus.btn_reset = 1'b1;
        for (int e = 0; e < 12; e++) begin
            step();
            got = obs();
            exp = {1'b0, 1'b0, (e == 6), (e >= 5), (e >= 5)};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL simultaneous e=%0d got=%b expected=%b", e, got, exp);
            end
        end
    endtask

    task automatic test_staggered();
        logic [4:0] got, exp;
        do_reset();
        bus.btn_set = 1'b1;
        for (int e = 0; e < 12; e++) begin
            step();
            if (e == 0) bus.btn_reset = 1'b1;
            got = obs();
            exp = {(e == 6), (e == 7), 1'b0, (e >= 5), (e >= 6)};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL staggered e=%0d got=%b expected=%b", e, got, exp);
            end
            n_cmp++;
            if ((bus.s & bus.r) !== 1'b0) begin
                n_bad++;
                $display("FAIL staggered_overlap e=%0d got s&r=%b expected=0", e, bus.s & bus.r);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] got, exp;
        int pulses;
        do_reset();
        pulses = 0;
        bus.btn_reset = 1'b1;
        for (int e = 0; e < 27; e++) begin
            step();
            if (e == 2)  rst = 1'b1;
            if (e == 3)  rst = 1'b0;
            if (e == 14) bus.btn_reset = 1'b0;
            got = obs();
            pulses += int'(got[3]);
            exp = {1'b0, (e == 10), 1'b0, 1'b0, (e >= 9) && (e < 20)};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL reset_mid e=%0d got=%b expected=%b", e, got, exp);
            end
        end
        bus.btn_reset = 1'b1;
        for (int f = 0; f < 12; f++) begin
            step();
            got = obs();
            pulses += int'(got[3]);
            exp = {1'b0, (f == 6), 1'b0, 1'b0, (f >= 5)};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL reset_mid_repress f=%0d got=%b expected=%b", f, got, exp);
            end
        end
        n_cmp++;
        if (pulses !== 2) begin
            n_bad++;
            $display("FAIL reset_mid_pulse_count got=%0d expected=2", pulses);
        end
        bus.btn_reset = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.btn_set   = 1'b0;
        bus.btn_reset = 1'b0;
        test_reset();
        test_clean_set();
        test_bounce();
        test_simultaneous();
        test_staggered();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
